// File: rtl/costas_pkg.sv
// Shared types and constants for the Costas/PSK beacon symbol timer.
package costas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int          CH_COSTAS = 0;
  localparam int          CH_PSK    = 1;
  localparam int unsigned CLK_HZ    = 27_000_000;

  // Symbol-period divisor for a symbol rate in whole symbols per second.
  function automatic int unsigned div_from_hz(input int unsigned sym_hz);
    return (sym_hz == 0) ? 0 : CLK_HZ / sym_hz;
  endfunction

endpackage

// File: rtl/costas_rate_div.sv
// Symbol-period counter for the active channel: counts 0..D-1 with D = max(div, 2).
module costas_rate_div #(
  parameter int DIV_W = 24
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_first,
  output logic             o_half,
  output logic             o_tc
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] w_d;

  assign w_d     = (i_div < DIV_W'(2)) ? DIV_W'(2) : i_div;
  assign o_first = (r_count == '0);
  assign o_half  = (r_count < (w_d >> 1));
  assign o_tc    = i_en && (r_count == w_d - DIV_W'(1));

  // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_en || o_tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/costas_symbol_timer.sv
// Multi-channel symbol-timing engine: arbitrates transmit requests onto one shared
// divider and produces trigger, symbol clock and DDS update strobes.
module costas_symbol_timer
  import costas_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 24,
  parameter int SYM_W  = 8
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    pps,
  input  logic [NUM_CH-1:0]       txrq,
  input  logic                    abort,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic [NUM_CH*SYM_W-1:0] nsym,
  input  logic [NUM_CH-1:0]       pps_align,
  output logic [NUM_CH-1:0]       trigger,
  output logic [NUM_CH-1:0]       sym_clk,
  output logic                    fq_ud,
  output logic [SYM_W-1:0]        sym_idx,
  output logic                    busy,
  output logic [NUM_CH-1:0]       done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [DIV_W-1:0]  r_div;
  logic [SYM_W-1:0]  r_nsym;
  logic [SYM_W-1:0]  r_sym_idx;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_txrq_q;
  logic [NUM_CH-1:0] r_done;
  logic              r_pps_meta;
  logic              r_pps_sync;
  logic              r_pps_prev;

  logic [CH_W-1:0]   w_grant_ch;
  logic [DIV_W-1:0]  w_sel_div;
  logic [SYM_W-1:0]  w_sel_nsym;
  logic              w_sel_align;
  logic [NUM_CH-1:0] w_grant_vec;
  logic [NUM_CH-1:0] w_ch_vec;
  logic [NUM_CH-1:0] w_active;
  logic [NUM_CH-1:0] w_txrq_rise;
  logic [NUM_CH-1:0] w_pending_nxt;
  logic              w_pps_rise;
  logic              w_run;
  logic              w_first;
  logic              w_half;
  logic              w_tc;

  // Lowest pending index wins; loop runs high-to-low so the last hit is the winner.
  always_comb begin
    // NOTE: defaults before the loop so every path assigns these and no latch is inferred.
    w_grant_ch  = '0;
    w_sel_div   = '0;
    w_sel_nsym  = '0;
    w_sel_align = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_grant_ch  = CH_W'(i);
        w_sel_div   = div[i*DIV_W +: DIV_W];
        w_sel_nsym  = nsym[i*SYM_W +: SYM_W];
        w_sel_align = pps_align[i];
      end
    end
  end

  assign w_run         = (r_state == RUN);
  assign w_ch_vec      = NUM_CH'(1) << r_ch;
  assign w_active      = (r_state != IDLE) ? w_ch_vec : '0;
  assign w_grant_vec   = ((r_state == IDLE) && (|r_pending)) ? (NUM_CH'(1) << w_grant_ch) : '0;
  assign w_txrq_rise   = txrq & ~r_txrq_q;
  assign w_pending_nxt = (r_pending | (w_txrq_rise & ~w_active)) & ~w_grant_vec;
  assign w_pps_rise    = r_pps_sync & ~r_pps_prev;

  costas_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .sys_clk (sys_clk),
    .rst     (rst),
    .i_en    (w_run),
    .i_div   (r_div),
    .o_first (w_first),
    .o_half  (w_half),
    .o_tc    (w_tc)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_div      <= '0;
      r_nsym     <= '0;
      r_sym_idx  <= '0;
      r_pending  <= '0;
      r_txrq_q   <= '0;
      r_done     <= '0;
      r_pps_meta <= 1'b0;
      r_pps_sync <= 1'b0;
      r_pps_prev <= 1'b0;
    end else begin
      r_txrq_q   <= txrq;
      r_pps_meta <= pps;
      r_pps_sync <= r_pps_meta;
      r_pps_prev <= r_pps_sync;
      r_pending  <= w_pending_nxt;
      r_done     <= '0;

      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_ch   <= w_grant_ch;
            r_div  <= w_sel_div;
            r_nsym <= w_sel_nsym;
            if (w_sel_nsym == '0) begin
              r_done <= w_grant_vec;
            end else begin
              r_sym_idx <= '0;
              r_state   <= w_sel_align ? ARM : RUN;
            end
          end
        end

        ARM: begin
          if (abort) begin
            r_state <= IDLE;
            r_done  <= w_ch_vec;
          end else if (w_pps_rise) begin
            r_state <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_done  <= w_ch_vec;
          end else if (w_tc) begin
            if (r_sym_idx == r_nsym - SYM_W'(1)) begin
              r_state <= IDLE;
              r_done  <= w_ch_vec;
            end else begin
              r_sym_idx <= r_sym_idx + SYM_W'(1);
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign trigger = w_run ? w_ch_vec : '0;
  assign sym_clk = (w_run && w_half) ? w_ch_vec : '0;
  assign fq_ud   = w_run && w_first;
  assign sym_idx = r_sym_idx;
  assign busy    = (r_state != IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_costas_symbol_timer.sv
// Self-checking bench for costas_symbol_timer: directed scenarios plus randomized
// traffic compared every cycle against a transaction-schedule reference model.
module tb_costas_symbol_timer;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 24;
  localparam int SYM_W  = 8;

  logic                    sys_clk = 1'b0;
  logic                    rst;
  logic                    pps;
  logic [NUM_CH-1:0]       txrq;
  logic                    abort;
  logic [NUM_CH*DIV_W-1:0] div;
  logic [NUM_CH*SYM_W-1:0] nsym;
  logic [NUM_CH-1:0]       pps_align;
  logic [NUM_CH-1:0]       trigger;
  logic [NUM_CH-1:0]       sym_clk;
  logic                    fq_ud;
  logic [SYM_W-1:0]        sym_idx;
  logic                    busy;
  logic [NUM_CH-1:0]       done;

  always #5 sys_clk = ~sys_clk;

  costas_symbol_timer #(
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W),
    .SYM_W  (SYM_W)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .pps       (pps),
    .txrq      (txrq),
    .abort     (abort),
    .div       (div),
    .nsym      (nsym),
    .pps_align (pps_align),
    .trigger   (trigger),
    .sym_clk   (sym_clk),
    .fq_ud     (fq_ud),
    .sym_idx   (sym_idx),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each transaction is a scheduled window [start, end] of RUN cycles;
  // outputs inside the window follow from the cycle offset by division and modulo.
  int          m_edge, m_ch, m_d, m_nsym, m_start, m_end, m_last_idx, m_g, m_k;
  bit          m_active;
  bit [1:0]    m_pend, m_prev, m_rise, m_act;
  logic [1:0]  e_trig, e_sclk, e_done;
  logic        e_fq, e_busy;
  int          e_idx;

  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_pend = '0; m_prev = '0; m_last_idx = 0;
      e_trig = '0; e_sclk = '0; e_done = '0; e_fq = 1'b0; e_busy = 1'b0; e_idx = 0;
    end else begin
      m_edge++;
      m_rise = txrq & ~m_prev;
      m_prev = txrq;
      m_act  = m_active ? (2'b01 << m_ch) : 2'b00;
      e_done = '0;
      m_g    = -1;
      if (m_active) begin
        if (abort || (m_edge - 1 == m_end)) begin
          m_active = 1'b0;
          e_done   = 2'b01 << m_ch;
        end
      end else if (m_pend != 0) begin
        m_g    = m_pend[0] ? 0 : 1;
        m_ch   = m_g;
        m_d    = int'(div[m_g*DIV_W +: DIV_W]);
        m_d    = (m_d < 2) ? 2 : m_d;
        m_nsym = int'(nsym[m_g*SYM_W +: SYM_W]);
        if (m_nsym == 0) begin
          e_done = 2'b01 << m_g;
        end else begin
          m_active = 1'b1;
          m_start  = m_edge;
          m_end    = m_edge + m_nsym * m_d - 1;
        end
      end
      m_pend = m_pend | (m_rise & ~m_act);
      if (m_g >= 0) m_pend[m_g] = 1'b0;
      if (m_active) begin
        m_k        = m_edge - m_start;
        e_trig     = 2'b01 << m_ch;
        e_sclk     = ((m_k % m_d) < (m_d / 2)) ? (2'b01 << m_ch) : 2'b00;
        e_fq       = ((m_k % m_d) == 0);
        e_idx      = m_k / m_d;
        m_last_idx = e_idx;
        e_busy     = 1'b1;
      end else begin
        e_trig = '0; e_sclk = '0; e_fq = 1'b0; e_busy = 1'b0; e_idx = m_last_idx;
      end
    end
  end

  bit chk_en = 1'b0;
  int cyc = 0;
  int cnt_trig[NUM_CH], cnt_sclk[NUM_CH], cnt_done[NUM_CH], t_first[NUM_CH], t_done[NUM_CH];
  int cnt_fq, cnt_busy, max_idx;

  task automatic clear_counts();
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_trig[c] = 0; cnt_sclk[c] = 0; cnt_done[c] = 0; t_first[c] = -1; t_done[c] = -1;
    end
    cnt_fq = 0; cnt_busy = 0; max_idx = 0;
  endtask

  // Advance to the next falling edge, tally outputs and compare with the model.
  task automatic step(input int n = 1);
    for (int s = 0; s < n; s++) begin
      @(negedge sys_clk);
      cyc++;
      for (int c = 0; c < NUM_CH; c++) begin
        if (trigger[c]) begin
          cnt_trig[c]++;
          if (t_first[c] < 0) t_first[c] = cyc;
          if (int'(sym_idx) > max_idx) max_idx = int'(sym_idx);
        end
        if (sym_clk[c]) cnt_sclk[c]++;
        if (done[c]) begin
          cnt_done[c]++;
          t_done[c] = cyc;
        end
      end
      if (fq_ud) cnt_fq++;
      if (busy) cnt_busy++;
      if (chk_en) begin
        check("cyc_trigger", trigger, e_trig);
        check("cyc_sym_clk", sym_clk, e_sclk);
        check("cyc_fq_ud", fq_ud, e_fq);
        check("cyc_sym_idx", sym_idx, e_idx);
        check("cyc_busy", busy, e_busy);
        check("cyc_done", done, e_done);
      end
    end
  endtask

  task automatic set_ch(input int ch, input int d, input int n, input bit al);
    div[ch*DIV_W +: DIV_W]  = DIV_W'(d);
    nsym[ch*SYM_W +: SYM_W] = SYM_W'(n);
    pps_align[ch]           = al;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] mask);
    txrq = mask;
    step(1);
    txrq = '0;
  endtask

  int t0, n_wait;
  bit found;

  initial begin
    rst = 1'b1; pps = 1'b0; abort = 1'b0; txrq = '0; pps_align = '0; div = '0; nsym = '0;
    m_edge = 0;
    clear_counts();
    repeat (3) @(negedge sys_clk);
    check("rst_trigger", trigger, 0);
    check("rst_sym_clk", sym_clk, 0);
    check("rst_fq_ud", fq_ud, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sym_idx", sym_idx, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    step(4);

    // Basic single-channel transmission.
    set_ch(0, 10, 3, 1'b0);
    clear_counts();
    t0 = cyc;
    pulse(2'b01);
    step(44);
    check("basic_latency", t_first[0] - t0, 2);
    check("basic_trig_len", cnt_trig[0], 30);
    check("basic_fq_count", cnt_fq, 3);
    check("basic_sclk_high", cnt_sclk[0], 15);
    check("basic_max_idx", max_idx, 2);
    check("basic_done", cnt_done[0], 1);

    // Simultaneous requests: ch0 first, ch1 one cycle after ch0's done.
    set_ch(0, 4, 2, 1'b0);
    set_ch(1, 4, 2, 1'b0);
    clear_counts();
    pulse(2'b11);
    step(30);
    check("cont_trig0", cnt_trig[0], 8);
    check("cont_trig1", cnt_trig[1], 8);
    check("cont_done0", cnt_done[0], 1);
    check("cont_done1", cnt_done[1], 1);
    check("cont_run0_len", t_done[0] - t_first[0], 8);
    check("cont_gap", t_first[1] - t_done[0], 1);

    // Divisor clamp, odd divisor, zero-symbol request.
    set_ch(0, 1, 3, 1'b0);
    clear_counts();
    pulse(2'b01);
    step(15);
    check("div1_trig", cnt_trig[0], 6);
    check("div1_sclk", cnt_sclk[0], 3);
    set_ch(0, 5, 2, 1'b0);
    clear_counts();
    pulse(2'b01);
    step(18);
    check("div5_trig", cnt_trig[0], 10);
    check("div5_sclk", cnt_sclk[0], 4);
    set_ch(0, 7, 0, 1'b0);
    clear_counts();
    pulse(2'b01);
    step(10);
    check("nsym0_done", cnt_done[0], 1);
    check("nsym0_fq", cnt_fq, 0);
    check("nsym0_trig", cnt_trig[0], 0);
    check("nsym0_busy", cnt_busy, 0);

    // Abort during symbol 1 of a 5-symbol run.
    set_ch(0, 6, 5, 1'b0);
    clear_counts();
    pulse(2'b01);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      if (trigger[0] && sym_idx == 1) found = 1'b1;
    end
    check("abort_reach_sym1", found, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_trig_low", trigger[0], 0);
    check("abort_done", done[0], 1);
    step(20);
    check("abort_fq_total", cnt_fq, 2);
    check("abort_done_total", cnt_done[0], 1);

    // Randomized traffic with requests, divisors and aborts changing every cycle.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        set_ch(c, int'($urandom_range(1, 9)), int'($urandom_range(0, 4)), 1'b0);
        txrq[c] = ($urandom_range(0, 11) == 0);
      end
      abort = ($urandom_range(0, 79) == 0);
      step(1);
    end
    txrq = '0;
    abort = 1'b0;
    step(60);

    // Asynchronous reset mid-run drops everything, including a pending request.
    set_ch(0, 10, 5, 1'b0);
    set_ch(1, 3, 2, 1'b0);
    pulse(2'b01);
    step(12);
    pulse(2'b10);
    step(2);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_trigger", trigger, 0);
    check("arst_sym_clk", sym_clk, 0);
    check("arst_fq_ud", fq_ud, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sym_idx", sym_idx, 0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    chk_en = 1'b1;
    clear_counts();
    step(30);
    check("arst_pending_lost", cnt_busy, 0);
    set_ch(0, 3, 2, 1'b0);
    clear_counts();
    pulse(2'b01);
    step(12);
    check("arst_after_trig", cnt_trig[0], 6);
    check("arst_after_done", cnt_done[0], 1);

    // PPS-aligned start on ch1.
    chk_en = 1'b0;
    set_ch(1, 4, 2, 1'b1);
    clear_counts();
    pulse(2'b10);
    step(1000);
    check("arm_busy", busy, 1);
    check("arm_trig_cnt", cnt_trig[1], 0);
    check("arm_fq_cnt", cnt_fq, 0);
    pps = 1'b1;
    n_wait = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      n_wait++;
      if (trigger[1]) found = 1'b1;
    end
    pps = 1'b0;
    check("pps_run_seen", found, 1);
    check("pps_latency_ok", (n_wait >= 3 && n_wait <= 4), 1);
    step(20);
    check("pps_trig_len", cnt_trig[1], 8);
    check("pps_done", cnt_done[1], 1);
    check("pps_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
